// File: rtl/flash_seq_pkg.sv
// Shared types for the flash command sequencer: FSM encoding, command record
// and the power-on boot table.
package flash_seq_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned SEL_W        = 4;
  localparam int unsigned TMO_W        = 24;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned BOOT_MAX     = 8;
  localparam int unsigned RST_WAIT_CYC = 256;

  typedef enum logic [2:0] {
    RST_WAIT,
    SEL,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    GAP
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] flash_addr;
    logic [ADDR_W-1:0] ddr_addr;
    logic [ADDR_W-1:0] lens;
    logic              option;
    logic [SEL_W-1:0]  ctrl_sel;
  } flash_cmd_t;

  // Unused tail entries stay zero; BOOT_N selects how many are issued.
  localparam flash_cmd_t BOOT_TABLE [BOOT_MAX] = '{
    '{32'h0010_0000, 32'h0000_0000, 32'h0004_B000, 1'b0, 4'd1},
    '{32'h0020_0000, 32'h0010_0000, 32'h0004_B000, 1'b0, 4'd1},
    '{32'h0030_0000, 32'h0000_0000, 32'h0000_0400, 1'b0, 4'd2},
    '0, '0, '0, '0, '0
  };

endpackage

// File: rtl/flash_cmd_slot.sv
// One-deep holding slot for an MCU command; a request arriving on the clear
// cycle is accepted so back-to-back MCU traffic never sees a gap.
module flash_cmd_slot
  import flash_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  flash_cmd_t i_cmd,
  input  logic       i_clr,
  output logic       o_ack,
  output logic       o_full,
  output flash_cmd_t o_cmd
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ack  <= 1'b0;
      o_full <= 1'b0;
      o_cmd  <= '0;
    end else begin
      o_ack <= 1'b0;
      if (i_clr) o_full <= 1'b0;
      if (i_req && (!o_full || i_clr)) begin
        o_cmd  <= i_cmd;
        o_full <= 1'b1;
        o_ack  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_cmd_seq.sv
// Flash command sequencer: plays the boot table after reset, then serves MCU
// commands, handshaking each one with the flash controller under a watchdog.
module flash_cmd_seq
  import flash_seq_pkg::*;
#(
  parameter int unsigned BOOT_N      = 3,
  parameter int unsigned EN_HOLD     = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000,
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mcu_req,
  input  logic [31:0] i_mcu_flash_addrs,
  input  logic [31:0] i_mcu_ddr_addrs,
  input  logic [31:0] i_mcu_lens,
  input  logic        i_mcu_option,
  input  logic [3:0]  i_mcu_ctrl_sel,
  output logic        o_mcu_ack,
  output logic        o_mcu_full,
  output logic        o_en,
  output logic [31:0] o_flash_addrs,
  output logic [31:0] o_ddr_addrs,
  output logic [31:0] o_lens,
  output logic        o_option,
  output logic [3:0]  o_ctrl_sel,
  input  logic        i_busy,
  input  logic        i_flash_done,
  output logic        o_boot_done,
  output logic        o_seq_busy,
  output logic        o_timeout_err,
  output logic [7:0]  o_cmd_cnt
);

  seq_state_e       state;
  logic [TMO_W-1:0] cnt;
  logic [IDX_W-1:0] boot_idx;
  logic             cmd_is_boot;
  flash_cmd_t       cmd_q;
  flash_cmd_t       mcu_in;
  flash_cmd_t       slot_cmd;
  logic             boot_pend_c;
  logic             gap_done_c;
  logic             slot_clr_c;
  logic             tmo_c;

  assign mcu_in      = {i_mcu_flash_addrs, i_mcu_ddr_addrs, i_mcu_lens, i_mcu_option, i_mcu_ctrl_sel};
  assign boot_pend_c = boot_idx < IDX_W'(BOOT_N);
  assign gap_done_c  = (state == GAP) && (cnt == TMO_W'(GAP_CYC - 1));
  assign slot_clr_c  = gap_done_c && !cmd_is_boot;
  assign tmo_c       = cnt >= TIMEOUT_CYC;

  assign o_flash_addrs = cmd_q.flash_addr;
  assign o_ddr_addrs   = cmd_q.ddr_addr;
  assign o_lens        = cmd_q.lens;
  assign o_option      = cmd_q.option;
  assign o_ctrl_sel    = cmd_q.ctrl_sel;

  flash_cmd_slot u_slot (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_mcu_req),
    .i_cmd   (mcu_in),
    .i_clr   (slot_clr_c),
    .o_ack   (o_mcu_ack),
    .o_full  (o_mcu_full),
    .o_cmd   (slot_cmd)
  );

  // Sequencer FSM; cnt saturates and is cleared on every state entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= RST_WAIT;
      cnt           <= '0;
      boot_idx      <= '0;
      cmd_is_boot   <= 1'b0;
      cmd_q         <= '0;
      o_en          <= 1'b0;
      o_boot_done   <= 1'b0;
      o_seq_busy    <= 1'b1;
      o_timeout_err <= 1'b0;
      o_cmd_cnt     <= '0;
    end else begin
      if (cnt != '1) cnt <= cnt + 1'b1;
      o_seq_busy <= !((state == SEL) && !boot_pend_c && !o_mcu_full);
      if (boot_idx == IDX_W'(BOOT_N)) o_boot_done <= 1'b1;

      case (state)
        RST_WAIT: begin
          if (cnt == TMO_W'(RST_WAIT_CYC - 1)) begin
            state <= SEL;
            cnt   <= '0;
          end
        end
        SEL: begin
          if (boot_pend_c || o_mcu_full) begin
            cmd_q       <= boot_pend_c ? BOOT_TABLE[boot_idx[2:0]] : slot_cmd;
            cmd_is_boot <= boot_pend_c;
            o_en        <= 1'b1;
            o_cmd_cnt   <= o_cmd_cnt + 1'b1;
            state       <= ISSUE;
            cnt         <= '0;
          end
        end
        ISSUE: begin
          if (cnt == TMO_W'(EN_HOLD - 1)) begin
            o_en  <= 1'b0;
            state <= WAIT_BUSY;
            cnt   <= '0;
          end
        end
        WAIT_BUSY: begin
          if (i_busy) begin
            state <= WAIT_IDLE;
            cnt   <= '0;
          end else if (tmo_c) begin
            o_timeout_err <= 1'b1;
            state         <= GAP;
            cnt           <= '0;
          end
        end
        WAIT_IDLE: begin
          if (!i_busy || (cmd_q.option && i_flash_done)) begin
            state <= GAP;
            cnt   <= '0;
          end else if (tmo_c) begin
            o_timeout_err <= 1'b1;
            state         <= GAP;
            cnt           <= '0;
          end
        end
        GAP: begin
          if (gap_done_c) begin
            state <= SEL;
            cnt   <= '0;
            if (cmd_is_boot) boot_idx <= boot_idx + 1'b1;
          end
        end
        default: begin
          state <= RST_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_cmd_seq.md
FLASH_CMD_SEQ -- requirements
Module: flash_cmd_seq

Interface
REQ-001 SHALL have parameter BOOT_N, default 3: number of boot-table entries, range 1..8.
REQ-002 SHALL have parameter EN_HOLD, default 4: cycles o_en stays high per command, minimum 3.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 24'd12_000_000: watchdog limit per wait state.
REQ-004 SHALL have parameter GAP_CYC, default 16: idle cycles between consecutive commands.
REQ-005 i_clk  in  1  clock; i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_mcu_req  in  1  single-cycle MCU command request.
REQ-007 i_mcu_flash_addrs  in  32, i_mcu_ddr_addrs  in  32, i_mcu_lens  in  32, i_mcu_option  in  1, i_mcu_ctrl_sel  in  4: MCU command fields, valid with i_mcu_req.
REQ-008 o_mcu_ack  out  1  one-cycle pulse when the MCU command is latched; o_mcu_full  out  1  high while the MCU slot is occupied.
REQ-009 o_en  out  1, o_flash_addrs  out  32, o_ddr_addrs  out  32, o_lens  out  32, o_option  out  1, o_ctrl_sel  out  4: command to the flash controller.
REQ-010 i_busy  in  1, i_flash_done  in  1: status returned by the flash controller.
REQ-011 o_boot_done  out  1, o_seq_busy  out  1, o_timeout_err  out  1, o_cmd_cnt  out  8: status.

Function
REQ-012 States: RST_WAIT, SEL, ISSUE, WAIT_BUSY, WAIT_IDLE, GAP; one-hot or binary encoding is permitted.
REQ-013 RST_WAIT: hold 256 cycles after reset release, then go to SEL.
REQ-014 SEL: if boot index < BOOT_N, load boot entry[index]; else if the MCU slot is full, load the slot; else stay in SEL; a loaded command goes to ISSUE the next cycle.
REQ-015 Boot entries SHALL take absolute priority over a pending MCU command.
REQ-016 Command fields SHALL be registered on load and held stable from ISSUE through WAIT_IDLE.
REQ-017 ISSUE: drive o_en=1 for exactly EN_HOLD cycles, then o_en=0 and go to WAIT_BUSY.
REQ-018 WAIT_BUSY: on i_busy=1 go to WAIT_IDLE; if the counter reaches TIMEOUT_CYC, set o_timeout_err and go to GAP.
REQ-019 WAIT_IDLE: on i_busy=0, or on i_flash_done=1 when o_option=1, go to GAP; same timeout rule as REQ-018.
REQ-020 GAP: wait GAP_CYC cycles, then go to SEL.
REQ-021 Leaving GAP from a boot command increments the boot index; from an MCU command it clears the MCU slot.
REQ-022 o_boot_done SHALL rise one cycle after the last boot entry leaves GAP and stay high until reset.
REQ-023 MCU slot is one deep: i_mcu_req with the slot empty latches the fields and pulses o_mcu_ack next cycle; with the slot full the request is dropped and no ack is given.
REQ-024 i_mcu_req in the same cycle the slot clears (GAP exit) SHALL be accepted.
REQ-025 o_seq_busy = 1 in every state except SEL with no command pending.
REQ-026 o_cmd_cnt increments by 1 on each ISSUE entry and wraps 255 -> 0.
REQ-027 o_timeout_err is sticky, cleared only by reset; sequencing continues after a timeout.
REQ-028 Timeout counter is 24 bits, clears on every state entry, and saturates.

Reset
REQ-029 On reset: state=RST_WAIT, o_en=0, all command outputs 0, o_mcu_ack=0, o_mcu_full=0, o_boot_done=0, o_seq_busy=1, o_timeout_err=0, o_cmd_cnt=0, boot index=0.
REQ-030 Reset mid-operation aborts the command immediately, drops o_en in the same edge, and restarts the boot table.

Structure
REQ-031 Package flash_seq_pkg SHALL hold the state encoding, the boot-entry record type (flash addr, ddr addr, lens, option, ctrl_sel), and the BOOT_TABLE constant.
REQ-032 BOOT_TABLE default entries:
- {0x0010_0000, 0x0000_0000, 0x4B000, 0, 1}
- {0x0020_0000, 0x0010_0000, 0x4B000, 0, 1}
- {0x0030_0000, 0, 0x400, 0, 2}
REQ-033 The MCU slot SHALL be a separate sub-module, flash_cmd_slot.

Verification
REQ-034 Reset release, controller model raising busy 3 cycles after o_en and holding it 500 cycles -> three commands issued in table order; o_cmd_cnt=3; o_boot_done=1; each o_en pulse exactly 4 cycles.
REQ-035 MCU req (flash 0x0040_0000, lens 0x100, option 1) during boot entry 1 -> o_mcu_ack next cycle; command issued only after o_boot_done; o_option held 1 until i_flash_done.
REQ-036 Second MCU req while slot full -> no ack; the dropped fields never appear on the outputs.
REQ-037 Model never raises busy -> o_timeout_err=1 after TIMEOUT_CYC (bench sets 1000); next entry still issued.
REQ-038 Assert reset during WAIT_IDLE of entry 2 -> o_en=0; after RST_WAIT, entry 0 is re-issued; o_cmd_cnt restarts at 1.
REQ-039 MCU req on the GAP-exit cycle of a previous MCU command -> accepted and acked.
